// File: rtl/std_sram_singleport_reqctl_if.sv
// Request and response channels of the single-port SRAM front-end.
// The master drives requests and consumes responses. The slave is the controller.
interface std_sram_singleport_reqctl_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/std_sram_singleport_reqctl.sv
// Single-port SRAM request controller. It issues accesses through a combinational path and
// tracks reads in flight with a valid pipe. A credit-gated in-order FIFO buffers the read data.
module std_sram_singleport_reqctl #(
  parameter int ADDR_WIDTH   = 1,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  std_sram_singleport_reqctl_if.slave bus,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]                        credit, cnt;
  logic [PW-1:0]                        wptr, rptr;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] fifo;
  logic [READ_LATENCY:1]                vld_pipe;
  logic                                 rd_iss, push, pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Every issued read reserves a FIFO slot until it is popped. The FIFO therefore cannot overflow.
  assign bus.req_ready = ~reset & (credit < DEPTH_C);
  assign sram_en       = bus.req_valid & bus.req_ready;
  assign sram_we       = bus.req_we & ~reset;
  assign sram_addr     = bus.req_addr;
  assign sram_din      = bus.req_wdata;
  assign rd_iss        = sram_en & ~bus.req_we;
  assign push          = vld_pipe[READ_LATENCY];
  assign bus.rsp_valid = (cnt != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_rdata = fifo[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      credit   <= '0;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      vld_pipe[1] <= rd_iss;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      credit <= credit + CW'(rd_iss) - CW'(pop);
      cnt    <= cnt + CW'(push) - CW'(pop);
      if (push) wptr <= ptr_nxt(wptr);
      if (pop)  rptr <= ptr_nxt(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= sram_dout;
  end
endmodule

// File: tb/tb_std_sram_singleport_reqctl.sv
// Bench for std_sram_singleport_reqctl with an 8-bit SRAM, a read latency of 2 and a 4-entry FIFO.
// It uses directed tables and sequences, and compares random traffic against a queue model.
module tb_std_sram_singleport_reqctl;
  localparam int AW = 8, DW = 8, RL = 2, DEPTH = 4;

  logic clk, reset;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  std_sram_singleport_reqctl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  std_sram_singleport_reqctl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with a two-stage registered output. Address i is preloaded with 0xA0 ^ i.
  logic [7:0] smem [256];
  logic [7:0] s1, s2;
  initial for (int i = 0; i < 256; i++) smem[i] <= 8'hA0 ^ i[7:0];
  always @(posedge clk) begin
    if (sram_en & sram_we) smem[sram_addr] <= sram_din;
    s1 <= smem[sram_addr];
    s2 <= s1;
  end
  assign sram_dout = s2;

  int ncmp = 0, nerr = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic drv(input logic v, input logic we, input logic [7:0] a, input logic [7:0] wd,
                     input logic rr);
    bus.req_valid = v; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd; bus.rsp_ready = rr;
  endtask

  task automatic do_reset();
    reset = 1'b1; drv(0, 0, 0, 0, 1);
    tick(); tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       vld, we;
    logic [7:0] addr, wdata;
    logic       rrdy;
    logic       e_rdy, e_en, e_we, e_rv;
    logic [7:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [7:0] a,
                              input logic [7:0] wd, input logic rdy, input logic en,
                              input logic ewe, input logic rv, input logic [7:0] rd);
    vec_t t;
    t.vld = v; t.we = we; t.addr = a; t.wdata = wd; t.rrdy = 1'b1;
    t.e_rdy = rdy; t.e_en = en; t.e_we = ewe; t.e_rv = rv; t.e_rd = rd;
    return t;
  endfunction

  typedef struct { logic [7:0] d; int av; } rsp_t;
  rsp_t       q [$];
  logic [7:0] refmem [256];
  vec_t       tbl [11];

  initial begin
    logic [7:0] e;
    logic v, we, rr, ev, er;
    logic [7:0] a, wd;
    int acc;

    for (int i = 0; i < 256; i++) refmem[i] = 8'hA0 ^ i[7:0];

    // Reset holds off issue even with a write request present.
    reset = 1'b1; drv(1, 1, 8'h11, 8'h22, 1);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_sram_en", 32'(sram_en), 0);
    chk("rst_sram_we", 32'(sram_we), 0);
    tick(); tick();
    reset = 1'b0; drv(0, 0, 0, 0, 1);
    #1;
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 1);
    tick();

    // Directed table: a single read of 5, then a write of 2 followed by a read of 2.
    tbl[0]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 0, 8'h05, 8'h00, 1, 1, 0, 0, 8'h00);
    tbl[2]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    tbl[3]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    tbl[4]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'hA5);
    tbl[5]  = mk(1, 1, 8'h02, 8'h3C, 1, 1, 1, 0, 8'h00);
    tbl[6]  = mk(1, 0, 8'h02, 8'h00, 1, 1, 0, 0, 8'h00);
    tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    tbl[8]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h3C);
    tbl[10] = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].vld, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rrdy);
      #1;
      chk("tbl_req_ready", 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk("tbl_sram_en", 32'(sram_en), 32'(tbl[i].e_en));
      chk("tbl_sram_we", 32'(sram_we), 32'(tbl[i].e_we));
      chk("tbl_sram_addr", 32'(sram_addr), 32'(tbl[i].addr));
      chk("tbl_sram_din", 32'(sram_din), 32'(tbl[i].wdata));
      chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk("tbl_rsp_rdata", 32'(bus.rsp_rdata), 32'(tbl[i].e_rd));
      tick();
    end

    // Eight back-to-back reads with no backpressure, answered on eight consecutive cycles.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k < 8) drv(1, 0, 8'(40 + k), 0, 1); else drv(0, 0, 0, 0, 1);
      #1;
      if (k < 8) chk("b2b_req_ready", 32'(bus.req_ready), 1);
      chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(k >= 3 && k < 11));
      if (k >= 3 && k < 11) begin
        e = 8'hA0 ^ 8'(40 + k - 3);
        chk("b2b_rsp_rdata", 32'(bus.rsp_rdata), 32'(e));
      end
      tick();
    end

    // Backpressure: only four reads are accepted. The drain raises req_ready one cycle after the first pop.
    do_reset();
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drv(1, 0, 8'(10 + k), 0, 0);
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'(k < 4));
      if (sram_en) acc++;
      tick();
    end
    chk("bp_accepted", 32'(acc), 4);
    for (int d = 0; d < 6; d++) begin
      drv(0, 0, 0, 0, 1);
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'(d < 4));
      if (d < 4) begin
        e = 8'hA0 ^ 8'(10 + d);
        chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'(e));
      end
      chk("bp_drain_ready", 32'(bus.req_ready), 32'(d >= 1));
      tick();
    end

    // A reset that arrives while two reads are in flight discards both of them.
    do_reset();
    drv(1, 0, 8'd20, 0, 1); tick();
    drv(1, 0, 8'd21, 0, 1); tick();
    reset = 1'b1; drv(1, 1, 8'd22, 8'h55, 1);
    #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_sram_en", 32'(sram_en), 0);
    chk("mid_rst_sram_we", 32'(sram_we), 0);
    tick();
    reset = 1'b0; drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      #1; chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0); tick();
    end
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drv(1, 0, 8'd9, 0, 1); else drv(0, 0, 0, 0, 1);
      #1;
      chk("after_rst_rsp_valid", 32'(bus.rsp_valid), 32'(k == 3));
      if (k == 3) chk("after_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0A9);
      tick();
    end

    // Random traffic against the model. Each accepted read becomes visible three cycles after acceptance.
    do_reset();
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      a  = 8'(32 + $urandom_range(0, 7));
      wd = 8'($urandom);
      rr = ($urandom_range(0, 2) != 0);
      drv(v, we, a, wd, rr);
      #1;
      er = (q.size() < DEPTH);
      ev = (q.size() > 0) && (q[0].av <= cyc);
      chk("rnd_req_ready", 32'(bus.req_ready), 32'(er));
      chk("rnd_sram_en", 32'(sram_en), 32'(v & er));
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      if (ev) chk("rnd_rsp_rdata", 32'(bus.rsp_rdata), 32'(q[0].d));
      if (ev && rr) void'(q.pop_front());
      if (v && er) begin
        if (we) refmem[a] = wd;
        else    q.push_back('{refmem[a], cyc + RL + 1});
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
